alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Sequencer driving the ALU control interface of the CPU model: the ALU is the consumer, this block is the producer.
//  Accepts one opcode at a time from the instruction decoder via valid/ready.
//  Fetches the operand onto the ALU data bus via a req/ack read handshake.
//  Pulses EALU plus exactly one active-low op select, then issues the accumulator write.
//  Reports done or err per instruction.
// PARAMETERS
//  OPW       3   opcode width
//  WAIT_MAX  15  max FETCH cycles without rd_ack before timeout (counter width = $clog2(WAIT_MAX+1))
// PORTS
//  clk          in   1    system clock, rising edge
//  rst          in   1    reset, asynchronous, active-low
//  instr_valid  in   1    opcode valid from decoder
//  instr_ready  out  1    controller can accept an opcode (IDLE only)
//  opcode       in   OPW  000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LDA, 110/111 illegal
//  rd_req       out  1    operand read request; held until rd_ack or timeout
//  rd_ack       in   1    operand valid on ALU data bus this cycle
//  EALU         out  1    ALU enable, active-high
//  IADD         out  1    add select, active-low
//  ISUB         out  1    sub select, active-low
//  IAND         out  1    and select, active-low
//  IOR          out  1    or select, active-low
//  acc_we       out  1    accumulator write enable, 1 cycle
//  acc_src      out  1    accumulator source: 0 = alu_out, 1 = data bus (LDA)
//  done         out  1    instruction completed, 1-cycle pulse
//  err          out  1    illegal opcode or operand timeout, 1-cycle pulse
// BEHAVIOUR
//  - Opcode is latched into op_q on accept (instr_valid & instr_ready). All outputs are Moore decodes of state/op_q.
//  - Reset (rst=0) forces IDLE immediately, mid-operation included. Outputs during and after reset:
//    instr_ready=1, rd_req=0, EALU=0, {IADD,ISUB,IAND,IOR}=4'b1111, acc_we=0, acc_src=0, done=0, err=0.
//  - rd_req may drop without an ack on reset. Op selects are never glitched low.
//  - States: IDLE, DECODE, FETCH, EXEC, WB, ERR. Every state except FETCH lasts exactly 1 cycle.
//  - IDLE: instr_ready=1. Go to DECODE on accept; otherwise stay.
//  - DECODE: NOP -> WB with acc_we=0. Illegal opcode -> ERR. Otherwise -> FETCH and clear wait_cnt.
//  - FETCH: rd_req=1. Exit conditions:
//    rd_ack=1 -> EXEC (ALU ops) or WB (LDA);
//    rd_ack=0 and wait_cnt==WAIT_MAX -> ERR;
//    else wait_cnt++.
//    rd_ack in the same cycle as wait_cnt==WAIT_MAX: ack wins.
//  - EXEC: EALU=1 and exactly one select low. The ALU registers its result at the end of this cycle.
//    ADD {EALU,IADD,ISUB,IAND,IOR}=5'b10111, SUB 5'b11011, AND 5'b11101, OR 5'b11110.
//  - WB: acc_we=1 (0 for NOP) and done=1. acc_src=1 only for LDA. -> IDLE.
//  - ERR: err=1, no acc_we, no done. -> IDLE.
//  - Invariants: at most one select low per cycle; a select is low only while EALU=1. rd_req=0 outside FETCH.
//  - Throughput: instr_valid held high gives the next accept in the cycle after WB/ERR.
//  - rd_ack outside FETCH is ignored.
//  - Latency (accept at edge T, ack in first FETCH cycle):
//    ADD: DECODE T+1, FETCH T+2, EXEC T+3, WB/done T+4.
//    LDA: done at T+3. NOP: done at T+2.
// TESTING
//  1. Hold rst=0 from mid-FETCH -> rd_req=0 and selects 4'b1111 immediately; after release instr_ready=1.
//  2. ADD (001), rd_ack in 1st FETCH cycle -> one cycle of 5'b10111, next cycle acc_we=1, acc_src=0, done=1.
//  3. SUB/AND/OR -> single EXEC cycle with 5'b11011 / 5'b11101 / 5'b11110; no other cycle has EALU=1.
//  4. LDA (101) -> EALU never 1; acc_we=1 with acc_src=1 the cycle after rd_ack; done=1.
//  5. SUB, rd_ack never -> rd_req high 16 cycles, then err=1 for 1 cycle, acc_we=0.
//     Repeat with rd_ack on the 16th cycle -> EXEC, no err.
//  6. Opcode 111 -> err at DECODE+1, rd_req never 1.
//     Back-to-back ADD, OR with instr_valid held -> 2nd accept in the cycle after the 1st done.

Source files
------------

// File: rtl/alu_ctrl.sv
// ALU control sequencer: accepts an opcode, fetches its operand over req/ack,
// pulses EALU with one active-low select, then writes the accumulator.
module alu_ctrl #(
    parameter int OPW      = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] opcode,
    output logic           rd_req,
    input  logic           rd_ack,
    output logic           EALU,
    output logic           IADD,
    output logic           ISUB,
    output logic           IAND,
    output logic           IOR,
    output logic           acc_we,
    output logic           acc_src,
    output logic           done,
    output logic           err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    localparam logic [OPW-1:0] OP_NOP = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        FETCH,
        EXEC,
        WB,
        ERR
    } state_t;

    state_t         state, state_nxt;
    logic [OPW-1:0] op_q;
    logic [CW-1:0]  wait_cnt;
    logic           accept;
    logic           op_legal;
    logic           wait_max;

    assign accept   = instr_valid && instr_ready;
    assign op_legal = (op_q <= OP_LDA);
    assign wait_max = (wait_cnt == CW'(WAIT_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                op_q <= opcode;
            if (state == DECODE)
                wait_cnt <= '0;
            else if (state == FETCH && !rd_ack && !wait_max)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rd_req      = 1'b0;
        EALU        = 1'b0;
        IADD        = 1'b1;
        ISUB        = 1'b1;
        IAND        = 1'b1;
        IOR         = 1'b1;
        acc_we      = 1'b0;
        acc_src     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = DECODE;
            end
            DECODE: begin
                if (op_q == OP_NOP)
                    state_nxt = WB;
                else if (!op_legal)
                    state_nxt = ERR;
                else
                    state_nxt = FETCH;
            end
            FETCH: begin
                rd_req = 1'b1;
                // an ack on the final allowed cycle still completes the fetch
                if (rd_ack)
                    state_nxt = (op_q == OP_LDA) ? WB : EXEC;
                else if (wait_max)
                    state_nxt = ERR;
            end
            EXEC: begin
                EALU = 1'b1;
                IADD = (op_q != OP_ADD);
                ISUB = (op_q != OP_SUB);
                IAND = (op_q != OP_AND);
                IOR  = (op_q != OP_OR);
                state_nxt = WB;
            end
            WB: begin
                acc_we    = (op_q != OP_NOP);
                acc_src   = (op_q == OP_LDA);
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed table, hand sequences for reset and
// back-to-back issue, and randomized instructions against a per-instruction trace model.
module tb_alu_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic       rd_req;
    logic       rd_ack;
    logic       EALU, IADD, ISUB, IAND, IOR;
    logic       acc_we, acc_src, done, err;

    alu_ctrl #(.OPW(3), .WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .EALU        (EALU),
        .IADD        (IADD),
        .ISUB        (ISUB),
        .IAND        (IAND),
        .IOR         (IOR),
        .acc_we      (acc_we),
        .acc_src     (acc_src),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // [10] ready [9] rd_req [8] EALU [7:4] IADD..IOR [3] acc_we [2] acc_src [1] done [0] err
    logic [10:0] outv;
    assign outv = {instr_ready, rd_req, EALU, IADD, ISUB, IAND, IOR, acc_we, acc_src, done, err};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] pk(bit rdy, bit rq, bit ea, logic [3:0] sel,
                                       bit we, bit src, bit dn, bit er);
        return {rdy, rq, ea, sel, we, src, dn, er};
    endfunction

    localparam logic [10:0] IDLE_V = 11'b1_0_0_1111_0_0_0_0;

    // Reference model: the expected output sequence of one instruction, cycle by
    // cycle, from the cycle after accept up to and including the done/err cycle.
    typedef struct {
        logic [10:0] v;
        bit          ack;
    } step_t;

    step_t tr[$];

    function automatic logic [3:0] sel_for(logic [2:0] op);
        case (op)
            3'd1:    return 4'b0111;
            3'd2:    return 4'b1011;
            3'd3:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic push(input logic [10:0] v, input bit in_fetch, input bit ack);
        step_t s;
        s.v   = v;
        s.ack = in_fetch ? ack : bit'($urandom_range(0, 1));
        tr.push_back(s);
    endtask

    task automatic build_trace(input logic [2:0] op, input int ack_at);
        int n;
        tr.delete();
        push(pk(0, 0, 0, 4'hF, 0, 0, 0, 0), 0, 0);
        if (op == 3'd0) begin
            push(pk(0, 0, 0, 4'hF, 0, 0, 1, 0), 0, 0);
        end else if (op > 3'd5) begin
            push(pk(0, 0, 0, 4'hF, 0, 0, 0, 1), 0, 0);
        end else begin
            n = (ack_at <= WAIT_MAX) ? ack_at + 1 : WAIT_MAX + 1;
            for (int k = 0; k < n; k++)
                push(pk(0, 1, 0, 4'hF, 0, 0, 0, 0), 1, (k == ack_at));
            if (ack_at > WAIT_MAX) begin
                push(pk(0, 0, 0, 4'hF, 0, 0, 0, 1), 0, 0);
            end else begin
                if (op != 3'd5)
                    push(pk(0, 0, 1, sel_for(op), 0, 0, 0, 0), 0, 0);
                push(pk(0, 0, 0, 4'hF, 1, (op == 3'd5), 1, 0), 0, 0);
            end
        end
    endtask

    // one clock cycle: drive at the falling edge, compare the Moore outputs
    task automatic cyc(input bit v, input logic [2:0] op, input bit ack,
                       input logic [10:0] exp, input string name, output logic [10:0] got);
        @(negedge clk);
        instr_valid = v;
        opcode      = op;
        rd_ack      = ack;
        #1;
        got = outv;
        check(name, {21'd0, got}, {21'd0, exp});
    endtask

    task automatic run_instr(input logic [2:0] op, input int ack_at, input bit hold,
                             output int lat, output int ealu_n, output int rdreq_n,
                             output bit we, output bit src, output bit er);
        logic [10:0] g;
        lat = 0; ealu_n = 0; rdreq_n = 0; we = 0; src = 0; er = 0;
        cyc(1, op, bit'($urandom_range(0, 1)), IDLE_V, $sformatf("accept op%0d", op), g);
        build_trace(op, ack_at);
        for (int i = 0; i < tr.size(); i++) begin
            cyc(hold, 3'($urandom), tr[i].ack, tr[i].v,
                $sformatf("op%0d ack@%0d cyc%0d", op, ack_at, i + 1), g);
            if ((g[1] || g[0]) && lat == 0) lat = i + 1;
            if (g[8]) ealu_n++;
            if (g[9]) rdreq_n++;
            if (g[3]) begin we = 1; src = g[2]; end
            if (g[0]) er = 1;
        end
    endtask

    typedef struct {
        logic [2:0] op;
        int         ack_at;
        int         lat;
        bit         er;
        bit         we;
        bit         src;
        int         ealu_n;
        int         rdreq_n;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [10:0] g;
        int lat, ea, rq;
        bit we, src, er;

        // op, ack_at (>WAIT_MAX = never), latency-to-done/err, err, we, src, EALU cycles, rd_req cycles
        tbl.push_back('{3'd1,  0,  4, 0, 1, 0, 1,  1});
        tbl.push_back('{3'd2,  0,  4, 0, 1, 0, 1,  1});
        tbl.push_back('{3'd3,  2,  6, 0, 1, 0, 1,  3});
        tbl.push_back('{3'd4,  0,  4, 0, 1, 0, 1,  1});
        tbl.push_back('{3'd5,  0,  3, 0, 1, 1, 0,  1});
        tbl.push_back('{3'd0,  0,  2, 0, 0, 0, 0,  0});
        tbl.push_back('{3'd2, 99, 18, 1, 0, 0, 0, 16});
        tbl.push_back('{3'd2, 15, 19, 0, 1, 0, 1, 16});
        tbl.push_back('{3'd7,  0,  2, 1, 0, 0, 0,  0});
        tbl.push_back('{3'd6,  0,  2, 1, 0, 0, 0,  0});
        tbl.push_back('{3'd5, 15, 18, 0, 1, 1, 0, 16});

        rst = 1'b0; instr_valid = 1'b0; opcode = '0; rd_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(1, 3'd1, 1, IDLE_V, "in_reset", g);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        cyc(0, 3'd0, 0, IDLE_V, "after_reset", g);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].ack_at, 0, lat, ea, rq, we, src, er);
            check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d err", i), {31'd0, er}, {31'd0, tbl[i].er});
            check($sformatf("tbl%0d acc_we", i), {31'd0, we}, {31'd0, tbl[i].we});
            check($sformatf("tbl%0d acc_src", i), {31'd0, src}, {31'd0, tbl[i].src});
            check($sformatf("tbl%0d ealu_cycles", i), ea, tbl[i].ealu_n);
            check($sformatf("tbl%0d rdreq_cycles", i), rq, tbl[i].rdreq_n);
            cyc(0, 3'd0, 0, IDLE_V, $sformatf("tbl%0d back_to_idle", i), g);
        end

        // asynchronous reset while waiting in FETCH
        cyc(1, 3'd2, 0, IDLE_V, "rstseq accept", g);
        cyc(0, 3'd0, 0, pk(0, 0, 0, 4'hF, 0, 0, 0, 0), "rstseq decode", g);
        cyc(0, 3'd0, 0, pk(0, 1, 0, 4'hF, 0, 0, 0, 0), "rstseq fetch0", g);
        cyc(0, 3'd0, 0, pk(0, 1, 0, 4'hF, 0, 0, 0, 0), "rstseq fetch1", g);
        #2 rst = 1'b0;
        #1 check("rstseq immediate", {21'd0, outv}, {21'd0, IDLE_V});
        cyc(1, 3'd2, 1, IDLE_V, "rstseq held", g);
        cyc(1, 3'd2, 1, IDLE_V, "rstseq held2", g);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        cyc(0, 3'd0, 0, IDLE_V, "rstseq released", g);

        // back-to-back ADD then OR with instr_valid held: second accept right after done
        run_instr(3'd1, 0, 1, lat, ea, rq, we, src, er);
        check("b2b add latency", lat, 4);
        run_instr(3'd4, 0, 1, lat, ea, rq, we, src, er);
        check("b2b or latency", lat, 4);
        cyc(0, 3'd0, 0, IDLE_V, "b2b idle", g);

        // randomized instructions, random gaps, random stray acks
        for (int n = 0; n < 250; n++) begin
            int gap;
            int ack_at;
            logic [2:0] op;
            op     = 3'($urandom_range(0, 7));
            ack_at = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 3);
            run_instr(op, ack_at, bit'($urandom_range(0, 1)), lat, ea, rq, we, src, er);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++)
                cyc(0, 3'($urandom), bit'($urandom_range(0, 1)), IDLE_V, "rand gap", g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
